// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller.
// Register numbers, exception codes and the handler entry address.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/cp0_if.sv
// M-stage side bus of CP0: mtc0/mfc0 access, victim info, requests.
// The pipeline drives through master; cp0 sits on slave.
interface cp0_if;
  import cp0_pkg::*;

  logic        en;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Addr, CP0In, VPC, BDIn,
    output ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Addr, CP0In, VPC, BDIn,
    input  ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );

endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC registers, exception request and
// victim capture, mfc0 read mux. Request is combinational.
module cp0
  import cp0_pkg::*;
(
  input logic clk,
  input logic reset,
  cp0_if.slave bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd_data;

  // Request decode: EXL masks every source, interrupt outranks exception
  always_comb begin
    int_req = (|(bus.HWInt & im)) & ie & ~exl;
    exc_req = (bus.ExcCodeIn != EXC_INT) & ~exl;
    req     = int_req | exc_req;
    wr_sr   = bus.en & ~req & (bus.CP0Addr == REG_SR);
    wr_epc  = bus.en & ~req & (bus.CP0Addr == REG_EPC);
  end

  // Register file: reset, then capture, then mtc0/eret
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bus.BDIn;
        exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc      <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      end else begin
        if (wr_sr) begin
          im  <= bus.CP0In[15:10];
          ie  <= bus.CP0In[0];
          exl <= bus.CP0In[1];
        end
        if (bus.EXLClr) exl <= 1'b0;
        if (wr_epc) epc <= bus.CP0In;
      end
    end
  end

  // mfc0 read mux and outputs
  always_comb begin
    sr_val    = {16'b0, im, 8'b0, exl, ie};
    cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    rd_data   = '0;
    case (bus.CP0Addr)
      REG_SR:    rd_data = sr_val;
      REG_CAUSE: rd_data = cause_val;
      REG_EPC:   rd_data = epc;
      default:   rd_data = '0;
    endcase
  end

  assign bus.CP0Out = rd_data;
  assign bus.EPCOut = epc;
  assign bus.Req    = req;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus random
// traffic against a register-level reference model.
module tb_cp0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0;
  int nerr = 0;

  cp0_if bus();

  cp0 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  task automatic model_edge();
    logic r, i;
    logic [31:0] ipv;
    r = m_req();
    i = m_int();
    ipv = {26'd0, bus.HWInt} << 10;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (r) begin
      m_sr = m_sr | 32'h2;
      m_cause = ({31'd0, bus.BDIn} << 31) | ipv
              | ({27'd0, (i ? 5'd0 : bus.ExcCodeIn)} << 2);
      m_epc = bus.BDIn ? bus.VPC - 4 : bus.VPC;
    end else begin
      m_cause = (m_cause & 32'h8000_007C) | ipv;
      if (bus.en && bus.CP0Addr == 5'd12) m_sr = bus.CP0In & 32'h0000_FC03;
      if (bus.EXLClr) m_sr = m_sr & ~32'h2;
      if (bus.en && bus.CP0Addr == 5'd14) m_epc = bus.CP0In;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 0; bus.en = 0; bus.CP0Addr = 0; bus.CP0In = 0;
    bus.VPC = 0; bus.BDIn = 0; bus.ExcCodeIn = 0;
    bus.HWInt = 0; bus.EXLClr = 0;
  endtask

  task automatic clear_exl();
    idle();
    bus.EXLClr = 1;
    tick();
    bus.EXLClr = 0;
  endtask

  task automatic write_sr(input logic [31:0] v);
    idle();
    bus.en = 1; bus.CP0Addr = 5'd12; bus.CP0In = v;
    tick();
    bus.en = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int a = 12; a <= 14; a++) begin
      bus.CP0Addr = 5'(a);
      #1;
      nvec++;
      if (bus.CP0Out !== 32'd0) begin
        nerr++;
        $display("FAIL reset_read%0d: got %h exp 0", a, bus.CP0Out);
      end
    end
    nvec++;
    if (bus.Req !== 1'b0 || bus.EPCOut !== 32'd0) begin
      nerr++;
      $display("FAIL reset_out: req %b epc %h exp 0/0", bus.Req, bus.EPCOut);
    end
  endtask

  task automatic test_int_entry();
    write_sr(32'h0000_FC01);
    bus.HWInt = 6'b000100; bus.VPC = 32'h0000_1234;
    #1;
    nvec++;
    if (bus.Req !== 1'b1) begin
      nerr++;
      $display("FAIL int_req: got %b exp 1", bus.Req);
    end
    tick();
    bus.HWInt = 0;
    bus.CP0Addr = 5'd13;
    #1;
    nvec++;
    if (bus.CP0Out !== 32'h0000_1000) begin
      nerr++;
      $display("FAIL int_cause: got %h exp 00001000", bus.CP0Out);
    end
    bus.CP0Addr = 5'd12;
    #1;
    nvec++;
    if (bus.CP0Out !== 32'h0000_FC03) begin
      nerr++;
      $display("FAIL int_sr: got %h exp 0000fc03", bus.CP0Out);
    end
    nvec++;
    if (bus.EPCOut !== 32'h0000_1234) begin
      nerr++;
      $display("FAIL int_epc: got %h exp 00001234", bus.EPCOut);
    end
    clear_exl();
  endtask

  task automatic test_exc_bd();
    idle();
    bus.ExcCodeIn = 5'd12; bus.BDIn = 1; bus.VPC = 32'h0000_3010;
    #1;
    nvec++;
    if (bus.Req !== 1'b1) begin
      nerr++;
      $display("FAIL exc_req: got %b exp 1", bus.Req);
    end
    tick();
    idle();
    bus.CP0Addr = 5'd14;
    #1;
    nvec++;
    if (bus.CP0Out !== 32'h0000_300C) begin
      nerr++;
      $display("FAIL exc_epc: got %h exp 0000300c", bus.CP0Out);
    end
    bus.CP0Addr = 5'd13;
    #1;
    nvec++;
    if (bus.CP0Out !== 32'h8000_0030) begin
      nerr++;
      $display("FAIL exc_cause: got %h exp 80000030", bus.CP0Out);
    end
    bus.ExcCodeIn = 5'd4;
    #1;
    nvec++;
    if (bus.Req !== 1'b0) begin
      nerr++;
      $display("FAIL exc_nested: got %b exp 0", bus.Req);
    end
    clear_exl();
  endtask

  task automatic test_priority();
    write_sr(32'h0000_FC01);
    bus.HWInt = 6'b100000; bus.ExcCodeIn = 5'd10; bus.VPC = 32'h0000_2000;
    tick();
    idle();
    bus.CP0Addr = 5'd13;
    #1;
    nvec++;
    if (bus.CP0Out[6:2] !== 5'd0) begin
      nerr++;
      $display("FAIL prio_code: got %0d exp 0", bus.CP0Out[6:2]);
    end
    clear_exl();
  endtask

  task automatic test_mtc0_suppressed();
    idle();
    bus.ExcCodeIn = 5'd5; bus.VPC = 32'h0000_5000;
    bus.en = 1; bus.CP0Addr = 5'd14; bus.CP0In = 32'h0000_4000;
    tick();
    idle();
    #1;
    nvec++;
    if (bus.EPCOut !== 32'h0000_5000) begin
      nerr++;
      $display("FAIL mtc0_supp: got %h exp 00005000", bus.EPCOut);
    end
  endtask

  task automatic test_eret_pending();
    idle();
    bus.HWInt = 6'b000001;
    #1;
    nvec++;
    if (bus.Req !== 1'b0) begin
      nerr++;
      $display("FAIL eret_masked: got %b exp 0", bus.Req);
    end
    bus.EXLClr = 1;
    tick();
    bus.EXLClr = 0;
    bus.CP0Addr = 5'd12;
    #1;
    nvec++;
    if (bus.CP0Out[1] !== 1'b0) begin
      nerr++;
      $display("FAIL eret_exl: got %b exp 0", bus.CP0Out[1]);
    end
    nvec++;
    if (bus.Req !== 1'b1) begin
      nerr++;
      $display("FAIL eret_int: got %b exp 1", bus.Req);
    end
    tick();
    clear_exl();
  endtask

  task automatic test_random();
    logic [4:0] codes [6];
    codes = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd31};
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.en = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 3))
        0: bus.CP0Addr = 5'd12;
        1: bus.CP0Addr = 5'd13;
        2: bus.CP0Addr = 5'd14;
        default: bus.CP0Addr = 5'($urandom);
      endcase
      bus.CP0In = $urandom;
      bus.VPC = $urandom;
      bus.BDIn = 1'($urandom);
      bus.ExcCodeIn = ($urandom_range(0, 4) == 0) ?
                      codes[$urandom_range(0, 5)] : 5'd0;
      bus.HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      bus.EXLClr = $urandom_range(0, 5) == 0;
      #1;
      nvec++;
      if (bus.Req !== m_req()) begin
        nerr++;
        $display("FAIL rnd_req@%0d: got %b exp %b", n, bus.Req, m_req());
      end
      nvec++;
      if (bus.CP0Out !== m_read(bus.CP0Addr)) begin
        nerr++;
        $display("FAIL rnd_rd@%0d a%0d: got %h exp %h", n, bus.CP0Addr,
                 bus.CP0Out, m_read(bus.CP0Addr));
      end
      nvec++;
      if (bus.EPCOut !== m_epc) begin
        nerr++;
        $display("FAIL rnd_epc@%0d: got %h exp %h", n, bus.EPCOut, m_epc);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    reset = 1;
    test_reset();
    test_int_entry();
    test_exc_bd();
    test_priority();
    test_mtc0_suppressed();
    test_eret_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller for the P7 pipelined MIPS core, sitting beside the M stage. It raises `Req`, which forces the next-PC selector to the handler entry 0x0000_4180 and flushes the pipeline. It also records the victim PC, cause and branch-delay flag, and supplies `EPCOut` as the `eret` target. SR, Cause and EPC are accessible through `mfc0`/`mtc0`.

## Interface
- No parameters; constants come from the shared package.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  `mtc0` write strobe from M stage.
- `CP0Addr`  in  5  register number (12 SR, 13 Cause, 14 EPC) for read and write.
- `CP0In`  in  32  `mtc0` write data.
- `CP0Out`  out  32  `mfc0` read data, combinational on `CP0Addr`.
- `VPC`  in  32  PC of the instruction currently in M (victim PC).
- `BDIn`  in  1  M-stage instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  pipelined exception code; 0 means none.
- `HWInt`  in  6  external interrupt lines [7:2], level-sensitive.
- `EXLClr`  in  1  `eret` in M; clears EXL.
- `EPCOut`  out  32  current EPC, combinational.
- `Req`  out  1  take exception/interrupt this cycle, combinational.

## Operation
- SR fields:
  - IM = SR[15:10].
  - EXL = SR[1].
  - IE = SR[0].
  - All other SR bits read as 0 and ignore writes.
- Cause fields:
  - BD = Cause[31].
  - IP = Cause[15:10].
  - ExcCode = Cause[6:2].
  - All other Cause bits read as 0.
- IntReq = |(HWInt & IM) & IE & !EXL.
- ExcReq = (ExcCodeIn != 0) & !EXL.
- Req = IntReq | ExcReq.
- Priority: interrupt over exception. When IntReq, the recorded ExcCode is 0 (Int).
- On Req at the clock edge:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC (32-bit wrap, no saturation).
- IP <= HWInt every cycle, unconditionally, whether or not Req is asserted.
- EXLClr & !Req: EXL <= 0.
- `mtc0` (`en` & !Req):
  - Addr 12: writes IM, EXL, IE.
  - Addr 14: writes EPC, all 32 bits.
  - Addr 13 and other numbers: write ignored.
- `en` with Req: the write is suppressed; exception capture wins.
- `mtc0` to SR and EXLClr in the same cycle: EXLClr applies to EXL, `mtc0` applies to IM/IE.
- `mfc0` reads:
  - Addr 12: SR.
  - Addr 13: Cause (IP shows the registered, not live, value).
  - Addr 14: EPC.
  - Any other address: 0.
- ExcCode values, defined in the package:
  - Int 0.
  - AdEL 4.
  - AdES 5.
  - Syscall 8.
  - RI 10.
  - Ov 12.

## Timing
- Reset: SR, Cause and EPC all 0. After reset, `CP0Out`=0, `EPCOut`=0, and `Req`=0 unless `ExcCodeIn`≠0.
- `Req` has zero latency. It is asserted in the same cycle the causing instruction or interrupt is visible at M, so the selector can redirect the fetch of the next cycle.
- Register updates become visible one cycle after the edge. `mfc0` issued in the cycle after `mtc0` returns the new value.
- Once EXL=1, all Req sources are masked until EXLClr or `mtc0` clears EXL. This makes nested entries impossible.
- Reset asserted mid-handler clears EXL and EPC in the same edge. Reset has priority over Req, `en` and EXLClr.

## Structure
- Shared package holds:
  - Register numbers SR=12, Cause=13, EPC=14.
  - ExcCode constants.
  - Handler entry 32'h0000_4180, also used by the next-PC selector.
- No sub-module. A single flat block holds the three registers, the request logic and the read mux.

## Test plan
- Reset, then read addr 12/13/14 → 0, 0, 0; `Req`=0.
- `mtc0` SR=32'h0000_FC01, `HWInt`=6'b000100 → `Req`=1 in the same cycle. Next cycle: Cause=32'h0000_1000, EXL=1, EPC=`VPC`.
- `ExcCodeIn`=12, `BDIn`=1, `VPC`=32'h3010 → `Req`=1. Next cycle: EPC=32'h300C, Cause=32'h8000_0030. A second exception during EXL=1 → `Req`=0.
- Interrupt and `ExcCodeIn`=10 in the same cycle, IE=1 → ExcCode recorded as 0.
- `en`=1, addr 14, data 32'h4000 in the same cycle as Req → EPC holds `VPC`, not 32'h4000.
- EXL=1, EXLClr=1 → EXL=0 next cycle. A pending unmasked interrupt then raises `Req` one cycle later.
